// File: rtl/rv_plic_claim_pkg.sv
// ----------------------------------------------------------------------------
// rv_plic_claim_pkg
// Shared definitions for the PLIC hart-side claim/complete endpoint.
//   ID_NONE        : interrupt ID 0, reads back as "no interrupt"
//   claim_result_e : how a claim read was resolved
//   id_width()     : width of an interrupt ID for a given number of sources
// No ports (package).
// ----------------------------------------------------------------------------
package rv_plic_claim_pkg;

    localparam int unsigned ID_NONE = 0;

    typedef enum logic [1:0] {
        CLAIM_OK    = 2'd0,
        CLAIM_EMPTY = 2'd1,
        CLAIM_FULL  = 2'd2,
        CLAIM_BUSY  = 2'd3
    } claim_result_e;

    // An ID must index every source. At least one bit is kept so that a
    // degenerate configuration still elaborates.
    function automatic int unsigned id_width(input int unsigned n_source);
        return (n_source > 2) ? $clog2(n_source) : 1;
    endfunction

endpackage

// File: rtl/rv_plic_claim_timer.sv
// ----------------------------------------------------------------------------
// rv_plic_claim_timer
// Stall watchdog for the claim controller: a saturating cycle counter with a
// sticky flag. Only instantiated when RV_PLIC_CLAIM_TIMEOUT_EN is defined.
// Ports:
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   run_i     : count this cycle (something is in service)
//   clear_i   : restart the count (a complete landed, or nothing in service)
//   timeout_o : sticky, set once TimeoutCycles counting cycles elapse
// ----------------------------------------------------------------------------
module rv_plic_claim_timer
    import rv_plic_claim_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam int unsigned TimerW = $clog2(TimeoutCycles + 1);

    logic [TimerW-1:0] timer_q;
    logic              flag_q;
    logic              at_limit;
    logic              hit_limit;

    assign at_limit  = (timer_q == TimerW'(TimeoutCycles));
    // The flag rises on the same edge at which the counter reaches the limit.
    assign hit_limit = run_i && !clear_i && (timer_q == TimerW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            if (clear_i) begin
                timer_q <= '0;
            end else if (run_i && !at_limit) begin
                timer_q <= timer_q + TimerW'(1);
            end
            if (hit_limit) begin
                flag_q <= 1'b1;
            end
        end
    end

    assign timeout_o = flag_q;

endmodule

// File: rtl/rv_plic_claim_ctrl.sv
// ----------------------------------------------------------------------------
// rv_plic_claim_ctrl
// Hart-side claim/complete endpoint for one PLIC target. Resolves claim reads
// against the arbitrated irq/irq_id, applies complete writes, pulses the
// gateways and tracks the set of in-service sources (nesting depth is bounded
// by MaxOutstanding). ID 0 means "no interrupt" and is never claimable.
// Optional feature macro: RV_PLIC_CLAIM_TIMEOUT_EN (stall watchdog).
// Ports:
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   irq_i, irq_id_i       : best eligible interrupt of this target
//   claim_re_i            : claim read strobe
//   claim_rvalid_o/rdata_o: claim response one cycle later (0 = none/rejected)
//   complete_we_i/wdata_i : complete write strobe and ID
//   claim_o, complete_o   : one-hot pulses back to the gateways
//   active_o              : in-service bitmap
//   irq_o                 : interrupt to hart, masked while nesting is full
//   err_o                 : pulse on any rejected claim/complete
//   timeout_o             : sticky stall flag (0 without the macro)
// ----------------------------------------------------------------------------
module rv_plic_claim_ctrl
    import rv_plic_claim_pkg::*;
#(
    parameter  int unsigned N_SOURCE       = 32,
    parameter  int unsigned MaxOutstanding = 4,
    parameter  int unsigned TimeoutCycles  = 1024,
    localparam int unsigned SrcWidth       = id_width(N_SOURCE)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                irq_i,
    input  logic [SrcWidth-1:0] irq_id_i,
    input  logic                claim_re_i,
    output logic                claim_rvalid_o,
    output logic [SrcWidth-1:0] claim_rdata_o,
    input  logic                complete_we_i,
    input  logic [SrcWidth-1:0] complete_wdata_i,
    output logic [N_SOURCE-1:0] claim_o,
    output logic [N_SOURCE-1:0] complete_o,
    output logic [N_SOURCE-1:0] active_o,
    output logic                irq_o,
    output logic                err_o,
    output logic                timeout_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [N_SOURCE-1:0] active_q, active_d;
    logic [N_SOURCE-1:0] claim_vec, complete_vec;
    logic [N_SOURCE-1:0] claim_q, complete_q;
    logic [CntW-1:0]     count_q, count_d;
    logic [SrcWidth-1:0] rdata_q;
    logic                rvalid_q, err_q;
    logic                cnt_full;
    logic                claim_ok, claim_err;
    logic                complete_ok, complete_err;
    claim_result_e       claim_res;

    // With N_SOURCE not a power of two an ID field can encode sources that
    // do not exist.
    function automatic logic in_range(input logic [SrcWidth-1:0] id);
        return {1'b0, id} < (SrcWidth + 1)'(N_SOURCE);
    endfunction

    assign cnt_full = (count_q >= CntW'(MaxOutstanding));

    // Both requests are judged on the state before this cycle, so a claim and
    // a complete of the same ID resolve as "claim busy, complete applied".
    always_comb begin
        claim_res = CLAIM_OK;
        if (!irq_i) begin
            claim_res = CLAIM_EMPTY;
        end else if ((irq_id_i == SrcWidth'(ID_NONE)) || !in_range(irq_id_i) ||
                     active_q[irq_id_i]) begin
            claim_res = CLAIM_BUSY;
        end else if (cnt_full) begin
            claim_res = CLAIM_FULL;
        end

        claim_ok     = claim_re_i && (claim_res == CLAIM_OK);
        claim_err    = claim_re_i && ((claim_res == CLAIM_FULL) || (claim_res == CLAIM_BUSY));
        complete_ok  = complete_we_i && (complete_wdata_i != SrcWidth'(ID_NONE)) &&
                       in_range(complete_wdata_i) && active_q[complete_wdata_i];
        complete_err = complete_we_i && !complete_ok;

        claim_vec    = claim_ok    ? (N_SOURCE'(1) << irq_id_i)         : '0;
        complete_vec = complete_ok ? (N_SOURCE'(1) << complete_wdata_i) : '0;

        active_d = (active_q | claim_vec) & ~complete_vec;
        // Cannot wrap: an accepted claim needs room, an accepted complete
        // needs an active source.
        count_d  = count_q + CntW'(claim_ok) - CntW'(complete_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q   <= '0;
            count_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            claim_q    <= '0;
            complete_q <= '0;
            err_q      <= 1'b0;
        end else begin
            active_q   <= active_d;
            count_q    <= count_d;
            rvalid_q   <= claim_re_i;
            rdata_q    <= claim_ok ? irq_id_i : SrcWidth'(ID_NONE);
            claim_q    <= claim_vec;
            complete_q <= complete_vec;
            err_q      <= claim_err || complete_err;
        end
    end

    assign claim_rvalid_o = rvalid_q;
    assign claim_rdata_o  = rdata_q;
    assign claim_o        = claim_q;
    assign complete_o     = complete_q;
    assign active_o       = active_q;
    assign err_o          = err_q;
    // Hold the hart off once no further nesting level is available.
    assign irq_o          = irq_i && !cnt_full;

`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
    rv_plic_claim_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .run_i    (count_q != '0),
        .clear_i  (complete_ok || (count_q == '0)),
        .timeout_o(timeout_o)
    );
`else
    assign timeout_o = 1'b0;
`endif

    a_params: assert property (@(posedge clk_i)
        (N_SOURCE >= 2) && (MaxOutstanding >= 1) && (MaxOutstanding < N_SOURCE) &&
        (TimeoutCycles >= 1));

    a_claim_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(claim_o));

    a_complete_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(complete_o));

    a_count_matches: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $countones(active_q) == int'(count_q));

    a_rvalid_after_re: assert property (@(posedge clk_i) disable iff (!rst_ni)
        claim_rvalid_o |-> $past(claim_re_i));

endmodule
